// File: rtl/dip_parallelizer.sv
// Serial-to-parallel front end for the external DIP/push-switch PISO chain.
// Pulses a load strobe each frame, shifts in DIP then switch bits, and publishes both words together.
module dip_parallelizer #(
    parameter int DIP_WIDTH = 16,
    parameter int SW_WIDTH  = 5
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET,
    input  logic                 i_Data,
    output logic [DIP_WIDTH-1:0] o_DIP16,
    output logic [SW_WIDTH-1:0]  o_Switch5,
    output logic                 o_DIPLatch
);

    localparam int N  = DIP_WIDTH + SW_WIDTH;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N-1:0]         shift_q, shift_d;
    logic [DIP_WIDTH-1:0] dip_q, dip_d;
    logic [SW_WIDTH-1:0]  sw_q, sw_d;
    logic [N-1:0]         frame_full;

    // The final bit is merged directly so both words update on the frame's last edge.
    assign frame_full = {shift_q[N-2:0], i_Data};

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dip_d   = dip_q;
        sw_d    = sw_q;
        if (cnt_q == '0) begin
            cnt_d = CW'(1);
        end else if (cnt_q < CNT_LAST) begin
            shift_d = frame_full;
            cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q == CNT_LAST) begin
            shift_d = frame_full;
            dip_d   = frame_full[N-1:SW_WIDTH];
            sw_d    = frame_full[SW_WIDTH-1:0];
            cnt_d   = '0;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cnt_q   <= '0;
            shift_q <= '0;
            dip_q   <= '0;
            sw_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dip_q   <= dip_d;
            sw_q    <= sw_d;
        end
    end

    assign o_DIP16    = dip_q;
    assign o_Switch5  = sw_q;
    assign o_DIPLatch = (cnt_q == '0);

endmodule

// File: tb/tb_dip_parallelizer.sv
// Self-checking bench for dip_parallelizer: directed scenarios plus random frames,
// compared every cycle against a frame-level reference model.
module tb_dip_parallelizer;

    localparam int DW = 16;
    localparam int SW = 5;
    localparam int N  = DW + SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic [DW-1:0] dip;
    logic [SW-1:0] sw;
    logic          latch;

    int checks = 0;
    int errors = 0;

    // reference model: frame position, collected bits, published words
    int        m_pos = 0;
    bit        m_bits[$];
    bit [DW-1:0] m_dip = '0;
    bit [SW-1:0] m_sw  = '0;

    int  cyc        = 0;
    bit  prev_latch = 1'b0;
    bit  period_chk = 1'b0;
    int  last_rise  = -1;
    int  n_periods  = 0;

    dip_parallelizer #(.DIP_WIDTH(DW), .SW_WIDTH(SW)) dut (
        .i_CLK     (clk),
        .i_RESET   (rst),
        .i_Data    (din),
        .o_DIP16   (dip),
        .o_Switch5 (sw),
        .o_DIPLatch(latch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic publish_frame();
        m_dip = '0;
        m_sw  = '0;
        for (int i = 0; i < DW; i++) m_dip += DW'(m_bits[i]) << (DW - 1 - i);
        for (int i = 0; i < SW; i++) m_sw  += SW'(m_bits[DW + i]) << (SW - 1 - i);
    endtask

    task automatic do_cycle(input bit r, input bit d);
        rst = r;
        din = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_pos = 0;
            m_bits.delete();
            m_dip = '0;
            m_sw  = '0;
        end else if (m_pos == 0) begin
            m_pos = 1;
        end else begin
            m_bits.push_back(d);
            if (m_pos == N) begin
                publish_frame();
                m_bits.delete();
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        #1;
        chk("latch", 32'(latch), 32'(m_pos == 0));
        chk("dip", 32'(dip), 32'(m_dip));
        chk("sw", 32'(sw), 32'(m_sw));
        if (period_chk && latch && !prev_latch) begin
            if (last_rise >= 0) begin
                chk("latch_period", 32'(cyc - last_rise), 32'(N + 1));
                n_periods++;
            end
            last_rise = cyc;
        end
        prev_latch = latch;
    endtask

    task automatic send_frame(input bit [N-1:0] bits_msb_first);
        do_cycle(1'b0, 1'($urandom_range(0, 1)));
        for (int i = N - 1; i >= 0; i--) do_cycle(1'b0, bits_msb_first[i]);
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b1;

        // reset hold with data high
        do_cycle(1'b1, 1'b1);
        do_cycle(1'b1, 1'b1);
        chk("reset_dip", 32'(dip), 32'h0000);
        chk("reset_sw", 32'(sw), 32'h00);
        chk("reset_latch", 32'(latch), 32'h1);

        // nominal frame
        send_frame({16'b1000_0110_0100_1000, 5'b10111});
        chk("nominal_dip", 32'(dip), 32'h8648);
        chk("nominal_sw", 32'(sw), 32'h17);
        chk("nominal_latch", 32'(latch), 32'h1);

        // stability: all ones, old words hold until the last edge
        do_cycle(1'b0, 1'b1);
        for (int i = 0; i < N - 1; i++) begin
            do_cycle(1'b0, 1'b1);
            chk("hold_dip", 32'(dip), 32'h8648);
        end
        do_cycle(1'b0, 1'b1);
        chk("ones_dip", 32'(dip), 32'hFFFF);
        chk("ones_sw", 32'(sw), 32'h1F);

        // latch periodicity over free-running random frames
        period_chk = 1'b1;
        last_rise  = cyc;
        for (int i = 0; i < 4 * (N + 1); i++) do_cycle(1'b0, 1'($urandom_range(0, 1)));
        period_chk = 1'b0;
        chk("period_count", 32'(n_periods), 32'd4);

        // reset after 10 bits of a frame
        do_cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'($urandom_range(0, 1)));
        do_cycle(1'b1, 1'b1);
        chk("midrst_dip", 32'(dip), 32'h0000);
        chk("midrst_sw", 32'(sw), 32'h00);
        chk("midrst_latch", 32'(latch), 32'h1);
        do_cycle(1'b1, 1'b0);
        send_frame({1'b1, 20'($urandom)});
        chk("midrst_msb", 32'(dip[15]), 32'h1);

        // alternating pattern
        send_frame(21'b1_0101_0101_0101_0101_0101);
        chk("alt_dip", 32'(dip), 32'hAAAA);
        chk("alt_sw", 32'(sw), 32'h15);

        // random frames
        for (int f = 0; f < 6; f++) send_frame(21'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
